multdiv_ctrl: RTL

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_pkg.sv | 23 ++
 rtl/wait_counter.sv | 29 ++
 rtl/multdiv_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide issue controller:
// FSM encoding, rstatus exception codes and timeout sizing.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT     = 40;
    localparam int RSTATUS_REG_DEFAULT = 30;

    localparam logic [31:0] RSTATUS_MULT = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;

    // Bits needed to hold every value from 0 up to max_count.
    function automatic int count_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Counts cycles spent waiting on the multdiv unit; 'last' flags the final
// permitted wait cycle so the controller can abort on the following edge.
module wait_counter
    import multdiv_pkg::*;
#(
    parameter int MAX_COUNT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int W = count_width(MAX_COUNT);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == W'(MAX_COUNT - 1));

endmodule

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller for a multi-cycle multiply/divide unit: latches
// operands, pulses the start strobe, waits with timeout, and requests writeback.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT     = TIMEOUT_DEFAULT,
    parameter int RSTATUS_REG = RSTATUS_REG_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        count_last;
    logic        capture;
    logic        expire;
    logic [4:0]  rd_q;
    logic        div_q;
    logic [31:0] result_q;
    logic        exc_q;

    wait_counter #(
        .MAX_COUNT(TIMEOUT)
    ) u_wait_counter (
        .clock (clock),
        .reset (reset),
        .clear (state == ISSUE),
        .enable((state == WAIT) && !data_resultRDY && !flush),
        .last  (count_last)
    );

    assign capture = (state == WAIT) && !flush && data_resultRDY;
    assign expire  = (state == WAIT) && !flush && !data_resultRDY && count_last;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if ((is_mult || is_div) && !flush) begin
                    next_state = ISSUE;
                    accept     = 1'b1;
                end
            end
            ISSUE:   next_state = flush ? IDLE : WAIT;
            WAIT: begin
                if (flush) begin
                    next_state = IDLE;
                end else if (capture || expire) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Start strobes are registered so they appear exactly during the ISSUE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ctrl_MULT     <= 1'b0;
            ctrl_DIV      <= 1'b0;
            data_operandA <= '0;
            data_operandB <= '0;
            rd_q          <= '0;
            div_q         <= 1'b0;
            result_q      <= '0;
            exc_q         <= 1'b0;
        end else begin
            state     <= next_state;
            ctrl_MULT <= accept && is_mult;
            ctrl_DIV  <= accept && !is_mult;
            if (accept) begin
                data_operandA <= opA;
                data_operandB <= opB;
                rd_q          <= rd;
                div_q         <= !is_mult;
            end
            if (capture) begin
                result_q <= data_result;
                exc_q    <= data_exception;
            end else if (expire) begin
                result_q <= '0;
                exc_q    <= 1'b1;
            end
        end
    end

    always_comb begin
        stall    = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        case (state)
            IDLE:  stall = (is_mult || is_div) && !flush;
            ISSUE: stall = 1'b1;
            WAIT:  stall = 1'b1;
            DONE: begin
                // Exceptions redirect the write to the status register.
                if (exc_q) begin
                    wb_valid = !flush;
                    wb_rd    = RSTATUS_RD;
                    wb_data  = div_q ? RSTATUS_DIV : RSTATUS_MULT;
                end else begin
                    wb_valid = !flush && (rd_q != 5'd0);
                    wb_rd    = rd_q;
                    wb_data  = result_q;
                end
            end
            default: stall = 1'b0;
        endcase
    end

endmodule
